// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared state and owner encodings for the IF/MA unified-memory arbiter.
package imem_dmem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_MA = 1'b1;

    // Width of a counter that must hold every value from 0 to max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_mem_arb_pick.sv
// Combinational winner select: MA by default, IF once it has been passed over STARVE_MAX times.
module mem_arb_pick
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned SW         = cnt_width(STARVE_MAX)
) (
    input  logic          i_if_req,
    input  logic          i_ma_req,
    input  logic [SW-1:0] i_starve_cnt,
    output logic          o_grant,
    output logic          o_owner
);

    logic w_if_starved;

    assign w_if_starved = i_if_req && (i_starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        o_grant = i_if_req | i_ma_req;
        o_owner = OWNER_IF;
        if (i_ma_req && !w_if_starved) begin
            o_owner = OWNER_MA;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// IDLE arbitrates, ISSUE holds the latched request on the bus, DONE pulses the owner's ack.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  flush,
    input  logic                  ma_req,
    input  logic                  ma_we,
    input  logic [DATA_W/8-1:0]   ma_be,
    input  logic [ADDR_W-1:0]     ma_addr,
    input  logic [DATA_W-1:0]     ma_wdata,
    output logic [DATA_W-1:0]     ma_rdata,
    output logic                  ma_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall_if,
    output logic                  stall_ma,
    output logic                  bus_err
);

    localparam int unsigned SW = cnt_width(STARVE_MAX);
    localparam int unsigned TW = cnt_width(TIMEOUT);

    state_t                r_state;
    logic                  r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_we;
    logic [DATA_W/8-1:0]   r_be;
    logic [DATA_W-1:0]     r_wdata;
    logic [SW-1:0]         r_starve;
    logic [TW-1:0]         r_tcnt;
    logic                  r_killed;
    logic                  r_bus_err;
    logic [DATA_W-1:0]     r_if_buf;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_ma_rdata;

    logic                  w_grant;
    logic                  w_owner;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_if_ack;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .i_if_req     (if_req),
        .i_ma_req     (ma_req),
        .i_starve_cnt (r_starve),
        .o_grant      (w_grant),
        .o_owner      (w_owner)
    );

    assign w_issue = (r_state == ST_ISSUE);
    assign w_done  = (r_state == ST_DONE);
    // Terminal ISSUE cycle: the counter would reach TIMEOUT at this edge.
    assign w_tmo   = w_issue && !mem_ready && (r_tcnt == TW'(TIMEOUT - 1));

    // A flush arriving in DONE still kills the fetch, so ack and data are gated here.
    assign w_if_ack = w_done && (r_owner == OWNER_IF) && !r_killed && !flush;

    assign if_ack    = w_if_ack;
    assign if_rdata  = w_if_ack ? r_if_buf : r_if_rdata;
    assign ma_ack    = w_done && (r_owner == OWNER_MA);
    assign ma_rdata  = r_ma_rdata;

    assign mem_req   = w_issue;
    assign mem_we    = w_issue && r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign stall_if  = if_req & ~if_ack;
    assign stall_ma  = ma_req & ~ma_ack;
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWNER_IF;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_starve   <= '0;
            r_tcnt     <= '0;
            r_killed   <= 1'b0;
            r_bus_err  <= 1'b0;
            r_if_buf   <= '0;
            r_if_rdata <= '0;
            r_ma_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state  <= ST_ISSUE;
                        r_owner  <= w_owner;
                        r_tcnt   <= '0;
                        r_killed <= 1'b0;
                        if (w_owner == OWNER_IF) begin
                            r_addr   <= if_addr;
                            r_we     <= 1'b0;
                            r_be     <= '1;
                            r_wdata  <= '0;
                            r_starve <= '0;
                        end else begin
                            r_addr  <= ma_addr;
                            r_we    <= ma_we;
                            r_be    <= ma_be;
                            r_wdata <= ma_wdata;
                            if (!if_req) begin
                                r_starve <= '0;
                            end else if (r_starve != SW'(STARVE_MAX)) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (flush && (r_owner == OWNER_IF)) begin
                        r_killed <= 1'b1;
                    end
                    if (mem_ready) begin
                        r_state <= ST_DONE;
                        if (r_owner == OWNER_IF) begin
                            r_if_buf <= mem_rdata;
                        end else if (!r_we) begin
                            r_ma_rdata <= mem_rdata;
                        end
                    end else if (w_tmo) begin
                        r_state   <= ST_DONE;
                        r_bus_err <= 1'b1;
                        if (r_owner == OWNER_IF) begin
                            r_if_buf <= '0;
                        end else begin
                            r_ma_rdata <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (w_if_ack) begin
                        r_if_rdata <= r_if_buf;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
